// File: rtl/systolic_mm_engine_if.sv
// Streaming job/result bus of the systolic matrix-multiply engine.
// master = job source / result sink, slave = engine.
interface systolic_mm_engine_if #(
  parameter int DIN_WIDTH = 8,
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int ACC_WIDTH = 2*DIN_WIDTH+8,
  parameter int ROW_IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1
);
  logic [7:0]                k_minus_one;
  logic                      signed_mode;
  logic                      in_valid;
  logic                      in_ready;
  logic [ROWS*DIN_WIDTH-1:0] in_a;
  logic [COLS*DIN_WIDTH-1:0] in_b;
  logic                      out_valid;
  logic                      out_ready;
  logic [COLS*ACC_WIDTH-1:0] out_data;
  logic [ROW_IDX_W-1:0]      out_row;
  logic                      out_last;
  logic                      busy;

  modport master (
    output k_minus_one, signed_mode, in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_last, busy
  );

  modport slave (
    input  k_minus_one, signed_mode, in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_row, out_last, busy
  );
endinterface

// File: rtl/systolic_mm_engine.sv
// Output-stationary ROWS x COLS systolic engine: C = A * B from K streamed
// (A column, B row) beats, results read out one C row per handshake.
module systolic_mm_engine #(
  parameter int DIN_WIDTH = 8,
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int ACC_WIDTH = 2*DIN_WIDTH+8,
  parameter int ROW_IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input logic                sys_clk,
  input logic                rst,
  systolic_mm_engine_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUTPUT} state_t;

  localparam int PW        = 2*DIN_WIDTH;
  localparam int DRAIN_CYC = ROWS + COLS - 1;
  localparam int DCNT_W    = $clog2(DRAIN_CYC + 1);

  state_t               state_reg, state_next;
  logic [7:0]           beat_cnt_reg;
  logic [7:0]           k_m1_reg;
  logic                 signed_reg;
  logic [DCNT_W-1:0]    drain_cnt_reg;
  logic [ROW_IDX_W-1:0] row_ptr_reg;

  logic in_ready_int, out_valid_int, busy_int;
  logic accept, start, shift_en, mode_eff, out_hs, last_row;

  assign accept   = bus.in_valid && in_ready_int;
  assign start    = accept && (state_reg == IDLE);
  assign shift_en = accept || (state_reg == LOAD) || (state_reg == DRAIN);
  // The first beat is multiplied before signed_reg has been loaded.
  assign mode_eff = (state_reg == IDLE) ? bus.signed_mode : signed_reg;
  assign out_hs   = out_valid_int && bus.out_ready;
  assign last_row = (row_ptr_reg == ROW_IDX_W'(ROWS - 1));

  always_ff @(posedge sys_clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = (bus.k_minus_one == 8'd0) ? DRAIN : LOAD;
      LOAD:    if (accept && (beat_cnt_reg == k_m1_reg)) state_next = DRAIN;
      DRAIN:   if (drain_cnt_reg == DCNT_W'(DRAIN_CYC - 1)) state_next = OUTPUT;
      OUTPUT:  if (out_hs && last_row) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready_int  = 1'b0;
    out_valid_int = 1'b0;
    busy_int      = 1'b0;
    if (!rst) begin
      case (state_reg)
        IDLE:    in_ready_int = 1'b1;
        LOAD:    begin in_ready_int = 1'b1; busy_int = 1'b1; end
        DRAIN:   busy_int = 1'b1;
        OUTPUT:  begin out_valid_int = 1'b1; busy_int = 1'b1; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      beat_cnt_reg  <= '0;
      k_m1_reg      <= '0;
      signed_reg    <= 1'b0;
      drain_cnt_reg <= '0;
      row_ptr_reg   <= '0;
    end else begin
      if (start) begin
        k_m1_reg     <= bus.k_minus_one;
        signed_reg   <= bus.signed_mode;
        beat_cnt_reg <= 8'd1;
      end else if (accept) begin
        beat_cnt_reg <= beat_cnt_reg + 8'd1;
      end
      drain_cnt_reg <= (state_reg == DRAIN) ? drain_cnt_reg + DCNT_W'(1) : '0;
      if (out_hs) row_ptr_reg <= last_row ? '0 : row_ptr_reg + ROW_IDX_W'(1);
    end
  end

  // Edge inputs: element i of each beat arrives i cycles late; idle cycles inject zeros.
  logic [ROWS-1:0][DIN_WIDTH-1:0] a_edge;
  logic [COLS-1:0][DIN_WIDTH-1:0] b_edge;

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_a_skew
    logic [DIN_WIDTH-1:0] a_beat;
    assign a_beat = accept ? bus.in_a[gi*DIN_WIDTH +: DIN_WIDTH] : '0;
    if (gi == 0) begin : g_direct
      assign a_edge[gi] = a_beat;
    end else begin : g_delay
      logic [DIN_WIDTH-1:0] sk_reg [gi];
      always_ff @(posedge sys_clk) begin
        if (rst) begin
          for (int k = 0; k < gi; k++) sk_reg[k] <= '0;
        end else if (shift_en) begin
          sk_reg[0] <= a_beat;
          for (int k = 1; k < gi; k++) sk_reg[k] <= sk_reg[k-1];
        end
      end
      assign a_edge[gi] = sk_reg[gi-1];
    end
  end

  for (genvar gi = 0; gi < COLS; gi++) begin : g_b_skew
    logic [DIN_WIDTH-1:0] b_beat;
    assign b_beat = accept ? bus.in_b[gi*DIN_WIDTH +: DIN_WIDTH] : '0;
    if (gi == 0) begin : g_direct
      assign b_edge[gi] = b_beat;
    end else begin : g_delay
      logic [DIN_WIDTH-1:0] sk_reg [gi];
      always_ff @(posedge sys_clk) begin
        if (rst) begin
          for (int k = 0; k < gi; k++) sk_reg[k] <= '0;
        end else if (shift_en) begin
          sk_reg[0] <= b_beat;
          for (int k = 1; k < gi; k++) sk_reg[k] <= sk_reg[k-1];
        end
      end
      assign b_edge[gi] = sk_reg[gi-1];
    end
  end

  logic [ROWS-1:0][COLS-1:0][DIN_WIDTH-1:0] a_fwd, b_fwd;
  logic [ROWS-1:0][COLS-1:0][ACC_WIDTH-1:0] acc_all;

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_pe
      logic [DIN_WIDTH-1:0] a_in, b_in, a_reg, b_reg;
      logic [PW-1:0]        a_ext, b_ext, prod;
      logic [ACC_WIDTH-1:0] prod_ext, acc_reg;

      if (gj == 0) begin : g_a_edge
        assign a_in = a_edge[gi];
      end else begin : g_a_left
        assign a_in = a_fwd[gi][gj-1];
      end
      if (gi == 0) begin : g_b_edge
        assign b_in = b_edge[gj];
      end else begin : g_b_up
        assign b_in = b_fwd[gi-1][gj];
      end

      assign a_ext = mode_eff ? {{DIN_WIDTH{a_in[DIN_WIDTH-1]}}, a_in} : {{DIN_WIDTH{1'b0}}, a_in};
      assign b_ext = mode_eff ? {{DIN_WIDTH{b_in[DIN_WIDTH-1]}}, b_in} : {{DIN_WIDTH{1'b0}}, b_in};
      assign prod  = a_ext * b_ext;
      assign prod_ext = mode_eff ? {{(ACC_WIDTH-PW){prod[PW-1]}}, prod}
                                 : {{(ACC_WIDTH-PW){1'b0}}, prod};

      // A new job restarts the sum with the product of its own first beat.
      always_ff @(posedge sys_clk) begin
        if (rst) begin
          a_reg   <= '0;
          b_reg   <= '0;
          acc_reg <= '0;
        end else if (shift_en) begin
          a_reg   <= a_in;
          b_reg   <= b_in;
          acc_reg <= (start ? '0 : acc_reg) + prod_ext;
        end
      end

      assign a_fwd[gi][gj]   = a_reg;
      assign b_fwd[gi][gj]   = b_reg;
      assign acc_all[gi][gj] = acc_reg;
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_int;
  assign bus.busy      = busy_int;
  assign bus.out_row   = out_valid_int ? row_ptr_reg : '0;
  assign bus.out_last  = out_valid_int && last_row;
  assign bus.out_data  = out_valid_int ? acc_all[row_ptr_reg] : '0;
endmodule

// File: tb/tb_systolic_mm_engine.sv
// Directed + randomized bench for systolic_mm_engine (4x4 and 2x3 instances)
// against a plain-arithmetic matrix product model.
module tb_systolic_mm_engine;
  localparam int DW = 8;
  localparam int AW = 24;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int R2 = 2;
  localparam int C2 = 3;

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;
  always #5 sys_clk = ~sys_clk;

  systolic_mm_engine_if #(.DIN_WIDTH(DW), .ROWS(R),  .COLS(C),  .ACC_WIDTH(AW)) bus ();
  systolic_mm_engine_if #(.DIN_WIDTH(DW), .ROWS(R2), .COLS(C2), .ACC_WIDTH(AW)) bus2 ();

  systolic_mm_engine #(.DIN_WIDTH(DW), .ROWS(R), .COLS(C), .ACC_WIDTH(AW)) dut (
    .sys_clk(sys_clk), .rst(rst), .bus(bus));
  systolic_mm_engine #(.DIN_WIDTH(DW), .ROWS(R2), .COLS(C2), .ACC_WIDTH(AW)) dut2 (
    .sys_clk(sys_clk), .rst(rst), .bus(bus2));

  int total = 0;
  int bad   = 0;
  int a_mat [R][256];
  int b_mat [256][C];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic longint opv(input int v, input bit sgn);
    return (sgn && v >= 128) ? longint'(v - 256) : longint'(v);
  endfunction

  function automatic logic [AW-1:0] ref_c(input int r, input int c, input int k_n, input bit sgn);
    longint s = 0;
    for (int k = 0; k < k_n; k++) s += opv(a_mat[r][k], sgn) * opv(b_mat[k][c], sgn);
    return AW'(s);
  endfunction

  function automatic logic [127:0] exp_row(input int r, input int ncols, input int k_n, input bit sgn);
    logic [127:0] v = '0;
    for (int c = 0; c < ncols; c++) v[c*AW +: AW] = ref_c(r, c, k_n, sgn);
    return v;
  endfunction

  task automatic fill_random();
    for (int r = 0; r < R; r++) for (int k = 0; k < 256; k++) a_mat[r][k] = int'($urandom_range(0, 255));
    for (int k = 0; k < 256; k++) for (int c = 0; c < C; c++) b_mat[k][c] = int'($urandom_range(0, 255));
  endtask

  task automatic fill_const(input int av, input int bv);
    for (int r = 0; r < R; r++) for (int k = 0; k < 256; k++) a_mat[r][k] = av;
    for (int k = 0; k < 256; k++) for (int c = 0; c < C; c++) b_mat[k][c] = bv;
  endtask

  // Drive k_n beats into the 4x4 engine; job parameters are scrambled after the first beat.
  task automatic drive_job(input int k_n, input bit sgn, input bit bubbles);
    int k = 0;
    int cyc = 0;
    bit acc;
    while (k < k_n && cyc < 4*k_n + 20) begin
      bus.in_valid = !(bubbles && (cyc % 2 == 1));
      for (int i = 0; i < R; i++)
        bus.in_a[i*DW +: DW] = bus.in_valid ? 8'(a_mat[i][k]) : 8'($urandom);
      for (int j = 0; j < C; j++)
        bus.in_b[j*DW +: DW] = bus.in_valid ? 8'(b_mat[k][j]) : 8'($urandom);
      if (k == 0 && bus.in_valid) begin
        bus.k_minus_one = 8'(k_n - 1);
        bus.signed_mode = sgn;
      end else begin
        bus.k_minus_one = 8'($urandom);
        bus.signed_mode = 1'($urandom);
      end
      acc = bus.in_valid && bus.in_ready;
      @(posedge sys_clk); #1;
      if (acc) k++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk("beats_accepted", 128'(k), 128'(k_n));
    chk("drain_in_ready", 128'(bus.in_ready), 128'(0));
    chk("drain_busy", 128'(bus.busy), 128'(1));
  endtask

  task automatic collect_job(input string tag, input int k_n, input bit sgn,
                             input int stall_row, input bit junk);
    int n = 0;
    if (junk) bus.in_valid = 1'b1;
    while (!bus.out_valid && n < 600) begin
      @(posedge sys_clk); #1;
      n++;
    end
    chk("latency", 128'(n), 128'(R + C - 1));
    for (int r = 0; r < R; r++) begin
      if (r == stall_row) begin
        repeat (5) begin
          @(posedge sys_clk); #1;
          chk("stall_data", bus.out_data, exp_row(r, C, k_n, sgn));
          chk("stall_row", 128'(bus.out_row), 128'(r));
          chk("stall_in_ready", 128'(bus.in_ready), 128'(0));
        end
      end
      if (r == R - 1) bus.in_valid = 1'b0;
      chk("out_valid", 128'(bus.out_valid), 128'(1));
      chk("out_row", 128'(bus.out_row), 128'(r));
      chk("out_last", 128'(bus.out_last), 128'(r == R - 1));
      chk("out_data", bus.out_data, exp_row(r, C, k_n, sgn));
      $display("dut1 %s K=%0d sgn=%0d row=%0d data=%h", tag, k_n, sgn, r, bus.out_data);
      bus.out_ready = 1'b1;
      @(posedge sys_clk); #1;
      bus.out_ready = 1'b0;
    end
    chk("done_busy", 128'(bus.busy), 128'(0));
    chk("done_in_ready", 128'(bus.in_ready), 128'(1));
  endtask

  task automatic drive2(input int k_n, input bit sgn, output int first_wait);
    int k = 0;
    int cyc = 0;
    bit acc;
    first_wait = 0;
    while (k < k_n && cyc < 2*k_n + 20) begin
      bus2.in_valid = 1'b1;
      for (int i = 0; i < R2; i++) bus2.in_a[i*DW +: DW] = 8'(a_mat[i][k]);
      for (int j = 0; j < C2; j++) bus2.in_b[j*DW +: DW] = 8'(b_mat[k][j]);
      bus2.k_minus_one = (k == 0) ? 8'(k_n - 1) : 8'($urandom);
      bus2.signed_mode = (k == 0) ? sgn : 1'($urandom);
      acc = bus2.in_ready;
      if (k == 0 && !acc) first_wait++;
      @(posedge sys_clk); #1;
      if (acc) k++;
      cyc++;
    end
    bus2.in_valid = 1'b0;
    chk("dut2_beats", 128'(k), 128'(k_n));
  endtask

  task automatic collect2(input int k_n, input bit sgn);
    int n = 0;
    while (!bus2.out_valid && n < 600) begin
      @(posedge sys_clk); #1;
      n++;
    end
    chk("dut2_latency", 128'(n), 128'(R2 + C2 - 1));
    bus2.out_ready = 1'b1;
    for (int r = 0; r < R2; r++) begin
      chk("dut2_out_row", 128'(bus2.out_row), 128'(r));
      chk("dut2_out_last", 128'(bus2.out_last), 128'(r == R2 - 1));
      chk("dut2_out_data", bus2.out_data, exp_row(r, C2, k_n, sgn));
      $display("dut2 K=%0d sgn=%0d row=%0d data=%h", k_n, sgn, r, bus2.out_data);
      @(posedge sys_clk); #1;
    end
    bus2.out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k_n;
    bit sgn;
    int fw;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in_a = '0; bus.in_b = '0;
    bus.k_minus_one = '0; bus.signed_mode = 1'b0;
    bus2.in_valid = 1'b0; bus2.out_ready = 1'b0; bus2.in_a = '0; bus2.in_b = '0;
    bus2.k_minus_one = '0; bus2.signed_mode = 1'b0;

    // Reset state
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst_in_ready", 128'(bus.in_ready), 128'(0));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_busy", 128'(bus.busy), 128'(0));
    chk("rst_out_data", bus.out_data, 128'(0));
    chk("rst_out_row", 128'(bus.out_row), 128'(0));
    chk("rst_out_last", 128'(bus.out_last), 128'(0));
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 128'(bus.in_ready), 128'(1));

    // Identity job, dense beats, exact latency
    for (int r = 0; r < R; r++) for (int k = 0; k < 4; k++) a_mat[r][k] = (r == k) ? 1 : 0;
    for (int k = 0; k < 4; k++) for (int c = 0; c < C; c++) b_mat[k][c] = 4*k + c + 1;
    drive_job(4, 1'b0, 1'b0);
    collect_job("identity", 4, 1'b0, -1, 1'b0);

    // Identity again with input bubbles, output stall on row 2, junk in_valid while busy
    drive_job(4, 1'b0, 1'b1);
    collect_job("identity_bubbles", 4, 1'b0, 2, 1'b1);

    // Random jobs, both arithmetic modes
    for (int t = 0; t < 4; t++) begin
      fill_random();
      k_n = int'($urandom_range(1, 12));
      sgn = 1'(t);
      drive_job(k_n, sgn, 1'(t >> 1));
      collect_job("random", k_n, sgn, -1, 1'b0);
    end

    // Unsigned full scale, K = 256
    fill_const(255, 255);
    drive_job(256, 1'b0, 1'b0);
    collect_job("full_scale", 256, 1'b0, -1, 1'b0);

    // K = 1: -128 * 127 signed, then the same bits unsigned
    fill_const(128, 127);
    drive_job(1, 1'b1, 1'b0);
    collect_job("signed_k1", 1, 1'b1, -1, 1'b0);
    drive_job(1, 1'b0, 1'b0);
    collect_job("unsigned_k1", 1, 1'b0, -1, 1'b0);

    // Reset after 2 of 4 beats, then a K = 1 job of ones
    fill_random();
    bus.k_minus_one = 8'd3; bus.signed_mode = 1'b0; bus.in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < R; i++) bus.in_a[i*DW +: DW] = 8'(a_mat[i][k]);
      for (int j = 0; j < C; j++) bus.in_b[j*DW +: DW] = 8'(b_mat[k][j]);
      @(posedge sys_clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("mid_job_busy", 128'(bus.busy), 128'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 128'(bus.in_ready), 128'(0));
    @(posedge sys_clk); #1;
    rst = 1'b0;
    #1;
    chk("after_rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("after_rst_busy", 128'(bus.busy), 128'(0));
    fill_const(1, 1);
    drive_job(1, 1'b0, 1'b0);
    collect_job("after_abort", 1, 1'b0, -1, 1'b0);

    // 2x3 instance: second job issued right after the first job's last handshake
    fill_random();
    drive2(6, 1'b0, fw);
    collect2(6, 1'b0);
    fill_random();
    drive2(5, 1'b1, fw);
    chk("b2b_first_accept_wait", 128'(fw), 128'(0));
    collect2(5, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/systolic_mm_engine.md
Name: systolic_mm_engine

Overview:
- Parametrised output-stationary ROWS x COLS systolic matrix-multiply engine; next generation of the fixed N x N sub-array.
- Computes C(ROWSxCOLS) = A(ROWSxK) * B(KxCOLS) from a streamed sequence of K slices: one column of A plus one row of B per beat.
- Adds rectangular arrays, a runtime signed/unsigned mode, valid/ready streaming on both sides and row-by-row result readout.
- Single clock domain; sits behind the input/output FIFOs of the top level.

Parameters:
- DIN_WIDTH, 8, operand element width in bits.
- ROWS, 4, array rows (elements of A per beat; rows of C).
- COLS, 4, array columns (elements of B per beat; elements per output row).
- ACC_WIDTH, 2*DIN_WIDTH+8, accumulator and output element width.
- ROW_IDX_W, $clog2(ROWS) (minimum 1), width of out_row.

Ports:
- sys_clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- k_minus_one  in  8  K-1; sampled on the first accepted beat of a job.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled with k_minus_one.
- in_valid  in  1  input beat valid.
- in_ready  out  1  engine accepts a beat.
- in_a  in  ROWS*DIN_WIDTH  A column; element i at bits [i*DIN_WIDTH +: DIN_WIDTH].
- in_b  in  COLS*DIN_WIDTH  B row; element j at bits [j*DIN_WIDTH +: DIN_WIDTH].
- out_valid  out  1  result row valid.
- out_ready  in  1  consumer accepts the row.
- out_data  out  COLS*ACC_WIDTH  C row out_row; element j at bits [j*ACC_WIDTH +: ACC_WIDTH].
- out_row  out  ROW_IDX_W  index of the row on out_data.
- out_last  out  1  high with the final row (out_row == ROWS-1).
- busy  out  1  high in LOAD, DRAIN and OUTPUT.

Behaviour:
- Reset: state = IDLE, beat counter = 0, row pointer = 0, skew and PE pipeline registers = 0, accumulators = 0. While rst is high: in_ready = 0, out_valid = 0, out_last = 0, busy = 0, out_row = 0, out_data = 0. rst mid-job aborts the job and discards all partial sums.
- FSM states: IDLE, LOAD, DRAIN, OUTPUT.
  - IDLE: in_ready = 1. On in_valid && in_ready: latch K-1 and signed_mode, clear all accumulators, count the beat. If K-1 == 0, go to DRAIN; otherwise go to LOAD.
  - LOAD: in_ready = 1. Count each accepted beat. The beat that completes K beats moves the FSM to DRAIN.
  - DRAIN: in_ready = 0. Lasts exactly ROWS+COLS-1 cycles, then go to OUTPUT.
  - OUTPUT: in_ready = 0, out_valid = 1. out_row starts at 0 and advances on out_valid && out_ready. out_data and out_row hold stable while out_ready is low. After the handshake with out_last high, return to IDLE; the next cycle accepts a new job.
- Dataflow:
  - A element i is delayed i cycles by skew registers and enters row i from the left.
  - B element j is delayed j cycles and enters column j from the top.
  - Each PE registers a and b and forwards them right and down. It accumulates a*b every cycle the array shifts.
  - The array shifts every cycle in LOAD and DRAIN. Cycles with no accepted beat inject zeros on both inputs, so input bubbles do not change results.
- Arithmetic:
  - Operands are sign-extended (signed_mode = 1) or zero-extended (signed_mode = 0) to 2*DIN_WIDTH before multiplying.
  - Products are extended to ACC_WIDTH and summed modulo 2^ACC_WIDTH: wrap, no saturation, no overflow flag.
- Latency: first out_valid occurs ROWS+COLS cycles after the cycle the final beat is accepted.
- Max K = 256. For unsigned full-scale operands the default ACC_WIDTH does not overflow.
- Simultaneous events: in_valid in DRAIN or OUTPUT is ignored and not consumed (in_ready = 0). A job's parameters are not affected by k_minus_one or signed_mode changing mid-job.

Test Plan:
- Identity, ROWS = COLS = 4, K = 4, unsigned: beat k has in_a = e_k and in_b = [4k+1, 4k+2, 4k+3, 4k+4] -> rows out as C row r = [4r+1..4r+4]; out_row = 0,1,2,3; out_last only on row 3; out_valid exactly 8 cycles after the last beat.
- Unsigned full scale: k_minus_one = 255, all operands 0xFF, 256 back-to-back beats -> every C element = 16646400 (0xFE0100); no wrap.
- Signed mode, k_minus_one = 0: in_a all 0x80 (-128), in_b all 0x7F (127) -> every element = -16256 (0xFFC080 in 24 bits). Repeat with signed_mode = 0 -> 16256.
- Bubbles and backpressure: rerun the identity job with in_valid high every other cycle -> identical C. Hold out_ready low 5 cycles at out_row = 2 -> out_data and out_row stable; in_ready = 0 throughout; no row skipped or duplicated.
- Reset mid-job: assert rst for 1 cycle after 2 of 4 beats -> next cycle state IDLE, in_ready = 1, busy = 0. Then a K = 1 job with all operands 1 -> every element = 1; no residue from the aborted job.
- Back-to-back jobs, ROWS = 2, COLS = 3 instance: issue the second job's first beat in the cycle after the first job's out_last handshake -> accepted immediately; both results correct.
